// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the byte-wide RAM port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LEN_BYTE     = 2'd0,
        LEN_HALF     = 2'd1,
        LEN_WORD     = 2'd2,
        LEN_WORD_ALT = 2'd3
    } mem_len_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        PauseDisable = 1'b1;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (mem_len_t'(len))
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM onto one byte-wide RAM port, serialising word
// accesses into byte cycles and reassembling read data little-endian.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_len,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_done,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  busy
);

    state_t                state, state_next;
    owner_t                owner;
    logic [2:0]            cnt, cnt_inc, n_bytes;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rbuf, rbuf_next;
    logic [7:0]            wbyte;
    logic                  ram_wr_q;
    logic                  arb_open, grant_mem, grant_if, flush_rd, last_rd;

    // A done pulse blocks arbitration for one cycle so the requester can drop its request.
    always_comb begin
        arb_open  = (state == ST_IDLE) && !if_done && !mem_done;
        grant_mem = arb_open && mem_req;
        grant_if  = arb_open && !mem_req && if_req;
        flush_rd  = (owner == OWN_IF) && if_flush;
        cnt_inc   = cnt + 3'd1;
        last_rd   = (cnt_inc == n_bytes);
        rbuf_next = rbuf;
        rbuf_next[{cnt[1:0], 3'b000} +: 8] = ram_din;
        wbyte     = wdata_q[{cnt[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable)
            state <= ST_IDLE;
        else if (rdy == PauseDisable)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_mem)
                    state_next = mem_we ? ST_WRITE : ST_READ;
                else if (grant_if)
                    state_next = ST_READ;
            end
            ST_READ:  if (flush_rd || last_rd) state_next = ST_IDLE;
            ST_WRITE: if (cnt == n_bytes) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_wr = (rdy == PauseDisable) ? ram_wr_q : WriteDisable;
        busy   = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            owner     <= OWN_IF;
            cnt       <= '0;
            n_bytes   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf      <= '0;
            ram_a     <= '0;
            ram_wr_q  <= WriteDisable;
            ram_dout  <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= ZeroWord;
            mem_rdata <= ZeroWord;
        end else if (rdy == PauseDisable) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_mem) begin
                        owner    <= OWN_MEM;
                        addr_q   <= mem_addr;
                        n_bytes  <= len_bytes(mem_len);
                        wdata_q  <= mem_wdata;
                        rbuf     <= '0;
                        ram_a    <= mem_addr;
                        ram_wr_q <= mem_we ? WriteEnable : WriteDisable;
                        cnt      <= mem_we ? 3'd1 : 3'd0;
                        if (mem_we)
                            ram_dout <= mem_wdata[7:0];
                    end else if (grant_if) begin
                        owner    <= OWN_IF;
                        addr_q   <= if_addr;
                        n_bytes  <= 3'd4;
                        wdata_q  <= '0;
                        rbuf     <= '0;
                        ram_a    <= if_addr;
                        ram_wr_q <= WriteDisable;
                        cnt      <= 3'd0;
                    end
                end
                ST_READ: begin
                    if (flush_rd) begin
                        rbuf <= '0;
                        cnt  <= '0;
                    end else if (last_rd) begin
                        cnt <= '0;
                        if (owner == OWN_IF) begin
                            if_rdata <= rbuf_next;
                            if_done  <= 1'b1;
                        end else begin
                            mem_rdata <= rbuf_next;
                            mem_done  <= 1'b1;
                        end
                    end else begin
                        rbuf  <= rbuf_next;
                        ram_a <= addr_q + ADDR_WIDTH'(cnt_inc);
                        cnt   <= cnt_inc;
                    end
                end
                ST_WRITE: begin
                    if (cnt == n_bytes) begin
                        ram_wr_q <= WriteDisable;
                        mem_done <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        ram_a    <= addr_q + ADDR_WIDTH'(cnt);
                        ram_dout <= wbyte;
                        cnt      <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
